quadrature_encoder_emulator: RTL and testbench
==============================================

// Module: quadrature_encoder_emulator
// PURPOSE
//  Generates A/B quadrature signals from host-commanded relative moves at a
//  programmable edge rate; the transmit-side counterpart of the team's
//  quadrature decoder. Used as an encoder emulator for HIL/bring-up and as
//  the decoder's loopback stimulus. Host side is a simple Avalon-MM slave.
// PARAMETERS
//  CLOCK_FREQ_HZ       50_000_000  clock frequency, documentation only
//  DEFAULT_PERIOD      1000        reset value of the period register, in clocks per edge (>=2)
//  COUNTS_PER_REV_LOG2 12          log2 of edges per revolution, for the index pulse only
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  address    in   2   register select
//  write      in   1   write strobe, single cycle
//  writedata  in   32  write data
//  read       in   1   read strobe
//  readdata   out  32  read data, combinational from address
//  channel_a  out  1   quadrature A, registered
//  channel_b  out  1   quadrature B, registered
//  busy       out  1   move in progress, registered
// BEHAVIOUR
//  Registers:
//   - addr0 W: signed 32-bit step command. Starts a move.
//   - addr0 R: signed remaining steps.
//   - addr1 R/W: period. Writes of 0 or 1 store 2.
//   - addr2 W: bit0 = abort, bit1 = clear overrun.
//   - addr2 R: {30'b0, overrun, busy}.
//   - addr3 R: signed position, i.e. net edges emitted.
//  Reset values: channel_a, channel_b, busy, remaining, position and overrun are 0;
//   phase = 0; period = DEFAULT_PERIOD. Assertion mid-move forces these immediately.
//  Phase encoding (A,B): 0=00, 1=01, 2=11, 3=10.
//   - A positive step sets phase to phase+1 mod 4.
//   - A negative step sets phase to phase-1 mod 4.
//   - The sequence matches the decoder's +1 convention.
//  FSM IDLE:
//   - A write to addr0 with a nonzero value latches remaining and direction.
//   - It loads timer = period-1 and goes to RUN. busy goes high on the next cycle.
//   - Writing 0 has no effect.
//  FSM RUN:
//   - The timer decrements every clock.
//   - At timer==0:
//     - advance one phase;
//     - position +/-1, wrapping 32-bit two's complement;
//     - remaining moves toward 0;
//     - reload timer from the current period register.
//   - When remaining reaches 0, go to IDLE; busy falls in the same cycle as the last edge.
//   - First edge appears exactly period clocks after the command-write cycle.
//   - Edge spacing equals period clocks.
//  Period written during RUN: takes effect at the next reload; the current interval is unchanged.
//  addr0 write during RUN: ignored and sets overrun (sticky). addr2 bit1 clears overrun.
//  Abort (addr2 bit0):
//   - Zeroes remaining and goes to IDLE; busy is 0 on the next cycle.
//   - A/B hold their current phase, with no glitch.
//  Abort and edge in the same cycle: the edge is emitted, then the move ends.
//  Abort + command in the same cycle: impossible, since there is a single address per write.
//  Command magnitude is handled as unsigned 32-bit, so -2^31 yields 2^31 steps.
//  A/B never change simultaneously. Outputs change only on clk, except reset.
// CONFIGURATION
//  QUAD_INDEX_PULSE_EN defined:
//   - Adds output port channel_z (1 bit, registered, reset 0).
//   - channel_z is high while position[COUNTS_PER_REV_LOG2-1:0]==0.
//   - It updates with A/B, so it is one edge-interval wide per revolution in either direction.
//  Not defined: no channel_z port and no related logic.
// TESTING
//  1. Reset -> A=B=0, busy=0. Reads: addr0=0, addr1=DEFAULT_PERIOD, addr2=0, addr3=0.
//  2. period=4, cmd=+8 -> 8 edges every 4 clks: 01,11,10,00,01,11,10,00.
//     First edge 4 clks after the write. Then busy=0 and addr3=8.
//  3. cmd=-3 from position 0 -> A/B sequence 10,11,01 and addr3=0xFFFFFFFD.
//  4. period=2, cmd=+10, abort after 2 edges -> A/B stay 11, busy=0 next clk, addr0=0, addr3=2.
//  5. cmd during busy -> move continues unchanged and addr2=3. Write addr2=2 -> addr2 bit1=0.
//  6. Write period=1 -> reads back 2. With QUAD_INDEX_PULSE_EN and LOG2=2, cmd=+9:
//     channel_z high at positions 4 and 8 only.

Source files
------------

// File: rtl/quadrature_encoder_emulator.sv
// quadrature_encoder_emulator
//   Emits A/B quadrature edges for host-commanded relative moves at a
//   programmable edge rate. Host access is an Avalon-MM style slave.
//
//   Register map (address):
//     0  W: signed step command (starts a move while idle)
//        R: signed remaining steps
//     1  R/W: period in clocks per edge (writes below 2 store 2)
//     2  W: bit0 abort, bit1 clear overrun
//        R: {30'b0, overrun, busy}
//     3  R: signed position (net edges emitted)
//
//   Ports:
//     clk, reset        system clock, asynchronous active-high reset
//     address, write,   host write port (single-cycle strobe)
//     writedata
//     read, readdata    host read port; readdata is combinational from address
//     channel_a/b       registered quadrature outputs
//     busy              registered move-in-progress flag
//     channel_z         registered index pulse (only with QUAD_INDEX_PULSE_EN)
//
//   Build option: define QUAD_INDEX_PULSE_EN to add channel_z, high while
//   the low COUNTS_PER_REV_LOG2 bits of position are zero.

module quadrature_encoder_emulator #(
  parameter int CLOCK_FREQ_HZ       = 50_000_000,
  parameter int DEFAULT_PERIOD      = 1000,
  parameter int COUNTS_PER_REV_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        channel_a,
  output logic        channel_b,
  output logic        busy
`ifdef QUAD_INDEX_PULSE_EN
  ,
  output logic        channel_z
`endif
);

  if (CLOCK_FREQ_HZ < 1 || DEFAULT_PERIOD < 2 ||
      COUNTS_PER_REV_LOG2 < 1 || COUNTS_PER_REV_LOG2 > 31) begin : g_bad_parameters
    $error("quadrature_encoder_emulator: illegal parameter value");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] period;
  logic [31:0] timer;
  logic [31:0] remaining;     // unsigned magnitude of steps still to emit
  logic [31:0] position;
  logic        dir_neg;
  logic        overrun;
  logic [1:0]  phase;

  logic        cmd_wr, period_wr, ctrl_wr, abort;
  logic        start, step_now;
  logic [1:0]  phase_next;
  logic [31:0] position_next;

  assign cmd_wr    = write && (address == 2'd0);
  assign period_wr = write && (address == 2'd1);
  assign ctrl_wr   = write && (address == 2'd2);
  assign abort     = ctrl_wr && writedata[0];

  assign phase_next    = dir_neg ? phase - 2'd1 : phase + 2'd1;
  assign position_next = dir_neg ? position - 32'd1 : position + 32'd1;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    step_now   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_wr && (writedata != '0)) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        step_now = (timer == '0);
        // A coincident abort still lets this cycle's edge out; it only ends the move.
        if ((step_now && (remaining == 32'd1)) || abort)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period    <= 32'(DEFAULT_PERIOD);
      timer     <= '0;
      remaining <= '0;
      position  <= '0;
      dir_neg   <= 1'b0;
      overrun   <= 1'b0;
      phase     <= '0;
      channel_a <= 1'b0;
      channel_b <= 1'b0;
`ifdef QUAD_INDEX_PULSE_EN
      channel_z <= 1'b0;
`endif
    end else begin
      if (start) begin
        dir_neg   <= writedata[31];
        // Magnitude taken as unsigned so -2^31 yields 2^31 steps.
        remaining <= writedata[31] ? -writedata : writedata;
        timer     <= period - 32'd1;
      end else if (state == RUN) begin
        if (step_now) begin
          phase     <= phase_next;
          // Gray mapping of phase 0..3 to AB 00,01,11,10.
          channel_a <= phase_next[1];
          channel_b <= ^phase_next;
          position  <= position_next;
          timer     <= period - 32'd1;
          remaining <= abort ? '0 : remaining - 32'd1;
`ifdef QUAD_INDEX_PULSE_EN
          channel_z <= (position_next[COUNTS_PER_REV_LOG2-1:0] == '0);
`endif
        end else begin
          timer <= timer - 32'd1;
          if (abort)
            remaining <= '0;
        end
      end

      if (period_wr)
        period <= (writedata < 32'd2) ? 32'd2 : writedata;

      if (ctrl_wr && writedata[1])
        overrun <= 1'b0;
      else if (cmd_wr && (state == RUN))
        overrun <= 1'b1;
    end
  end

  // readdata is driven only while read is asserted; zero otherwise.
  always_comb begin
    readdata = '0;
    if (read) begin
      unique case (address)
        2'd0:    readdata = dir_neg ? -remaining : remaining;
        2'd1:    readdata = period;
        2'd2:    readdata = {30'b0, overrun, busy};
        default: readdata = position;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// tb_quadrature_encoder_emulator
//   Self-checking bench for quadrature_encoder_emulator: directed scenarios
//   followed by randomized host traffic, checked every cycle against an
//   edge-scheduling reference model.

module tb_quadrature_encoder_emulator;

  localparam int DEF_P = 7;
  localparam int LOG2  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b1;
  logic [31:0] readdata;
  logic        channel_a, channel_b, busy;
`ifdef QUAD_INDEX_PULSE_EN
  logic        channel_z;
`endif

  quadrature_encoder_emulator #(
    .CLOCK_FREQ_HZ      (50_000_000),
    .DEFAULT_PERIOD     (DEF_P),
    .COUNTS_PER_REV_LOG2(LOG2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .read     (read),
    .readdata (readdata),
    .channel_a(channel_a),
    .channel_b(channel_b),
    .busy     (busy)
`ifdef QUAD_INDEX_PULSE_EN
    ,
    .channel_z(channel_z)
`endif
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: edges are scheduled at absolute cycle numbers.
  logic [31:0] m_pos, m_rem, m_period;
  int          m_phase;
  logic        m_neg, m_busy, m_ovr, m_z;
  longint      m_next;
  logic        prev_a, prev_b;

  logic [1:0]  seq[$];
  longint      edge_cyc[$];
  logic [31:0] zpos[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pos = '0; m_rem = '0; m_period = 32'(DEF_P);
    m_phase = 0; m_neg = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_z = 1'b0;
    m_next = 0;
    prev_a = 1'b0; prev_b = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [1:0] ad, input logic [31:0] wd);
    logic        was_busy;
    logic [31:0] old_period;
    was_busy   = m_busy;
    old_period = m_period;
    if (m_busy && cyc == m_next) begin
      m_phase = m_neg ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
      m_pos   = m_neg ? m_pos - 32'd1 : m_pos + 32'd1;
      m_rem   = m_rem - 32'd1;
      m_next  = cyc + longint'(old_period);
      m_z     = (m_pos % (32'd1 << LOG2)) == 0;
      if (m_rem == 0) m_busy = 1'b0;
    end
    if (wr) begin
      case (ad)
        2'd0: begin
          if (was_busy) m_ovr = 1'b1;
          else if (wd != 0) begin
            m_neg  = wd[31];
            m_rem  = wd[31] ? 32'd0 - wd : wd;
            m_busy = 1'b1;
            m_next = cyc + longint'(old_period);
          end
        end
        2'd1: m_period = (wd < 2) ? 32'd2 : wd;
        2'd2: begin
          if (wd[0] && was_busy) begin m_rem = '0; m_busy = 1'b0; end
          if (wd[1]) m_ovr = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] ad);
    case (ad)
      2'd0:    return m_neg ? 32'd0 - m_rem : m_rem;
      2'd1:    return m_period;
      2'd2:    return {30'b0, m_ovr, m_busy};
      default: return m_pos;
    endcase
  endfunction

  task automatic check_outputs();
    check_eq("chan_a", 32'(channel_a), 32'(m_phase >= 2));
    check_eq("chan_b", 32'(channel_b), 32'(m_phase == 1 || m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("readdata", readdata, model_read(address));
    check_eq("ab_single_change", 32'((channel_a != prev_a) && (channel_b != prev_b)), 32'd0);
`ifdef QUAD_INDEX_PULSE_EN
    check_eq("chan_z", 32'(channel_z), 32'(m_z));
`endif
    prev_a = channel_a;
    prev_b = channel_b;
  endtask

  task automatic step_cycle(input logic wr, input logic [1:0] ad, input logic [31:0] wd,
                            input logic [1:0] rd);
    write = wr; address = ad; writedata = wd;
    @(posedge clk);
    cyc++;
    model_edge(wr, ad, wd);
    #1;
    write = 1'b0; address = rd;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  // Idle cycles with random read address, logging every AB change.
  task automatic run_watch(input int cycles);
    logic [1:0] last;
    last = {channel_a, channel_b};
    seq.delete(); edge_cyc.delete();
    for (int i = 0; i < cycles; i++) begin
      step_cycle(1'b0, 2'd0, '0, 2'($urandom_range(0, 3)));
      if ({channel_a, channel_b} != last) begin
        last = {channel_a, channel_b};
        seq.push_back(last);
        edge_cyc.push_back(cyc);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  exp2[8];
    logic [1:0]  exp3[3];
    logic [31:0] exp_rst[4];
    longint      cmd_cyc;
    int          r;
    logic [31:0] wd;

    exp2    = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    exp3    = '{2'b10, 2'b11, 2'b01};
    exp_rst = '{32'd0, 32'(DEF_P), 32'd0, 32'd0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and register readback
    for (int a = 0; a < 4; a++) begin
      step_cycle(1'b0, 2'd0, '0, 2'(a));
      check_eq("t1_reset_read", readdata, exp_rst[a]);
    end

    // period 4, +8 steps
    step_cycle(1'b1, 2'd1, 32'd4, 2'd1);
    step_cycle(1'b1, 2'd0, 32'd8, 2'd0);
    cmd_cyc = cyc;
    run_watch(40);
    check_eq("t2_edge_count", 32'(seq.size()), 32'd8);
    for (int i = 0; i < seq.size() && i < 8; i++)
      check_eq("t2_ab_seq", 32'(seq[i]), 32'(exp2[i]));
    if (edge_cyc.size() > 0)
      check_eq("t2_first_edge_delay", 32'(edge_cyc[0] - cmd_cyc), 32'd4);
    for (int i = 1; i < edge_cyc.size(); i++)
      check_eq("t2_edge_spacing", 32'(edge_cyc[i] - edge_cyc[i-1]), 32'd4);
    step_cycle(1'b0, 2'd0, '0, 2'd3);
    check_eq("t2_position", readdata, 32'd8);
    check_eq("t2_busy_done", 32'(busy), 32'd0);

    // -3 from position 0
    do_reset();
    step_cycle(1'b1, 2'd0, 32'hFFFF_FFFD, 2'd0);
    run_watch(30);
    check_eq("t3_edge_count", 32'(seq.size()), 32'd3);
    for (int i = 0; i < seq.size() && i < 3; i++)
      check_eq("t3_ab_seq", 32'(seq[i]), 32'(exp3[i]));
    step_cycle(1'b0, 2'd0, '0, 2'd3);
    check_eq("t3_position", readdata, 32'hFFFF_FFFD);

    // abort after two edges at period 2
    do_reset();
    step_cycle(1'b1, 2'd1, 32'd2, 2'd1);
    step_cycle(1'b1, 2'd0, 32'd10, 2'd0);
    repeat (4) step_cycle(1'b0, 2'd0, '0, 2'd3);
    step_cycle(1'b1, 2'd2, 32'd1, 2'd0);
    check_eq("t4_busy_after_abort", 32'(busy), 32'd0);
    check_eq("t4_ab_hold", 32'({channel_a, channel_b}), 32'b11);
    check_eq("t4_remaining", readdata, 32'd0);
    repeat (5) step_cycle(1'b0, 2'd0, '0, 2'd3);
    check_eq("t4_position", readdata, 32'd2);
    check_eq("t4_ab_still", 32'({channel_a, channel_b}), 32'b11);

    // command while busy sets overrun, clear via addr2 bit1
    step_cycle(1'b1, 2'd1, 32'd3, 2'd1);
    step_cycle(1'b1, 2'd0, 32'd4, 2'd2);
    step_cycle(1'b1, 2'd0, 32'd5, 2'd2);
    check_eq("t5_status_overrun", readdata, 32'd3);
    repeat (20) step_cycle(1'b0, 2'd0, '0, 2'd3);
    check_eq("t5_position", readdata, 32'd6);
    step_cycle(1'b1, 2'd2, 32'd2, 2'd2);
    check_eq("t5_status_cleared", readdata, 32'd0);

    // period clamp and -2^31 magnitude
    step_cycle(1'b1, 2'd1, 32'd1, 2'd1);
    check_eq("t6_period_clamp", readdata, 32'd2);
    step_cycle(1'b1, 2'd1, 32'd0, 2'd1);
    check_eq("t6_period_clamp0", readdata, 32'd2);
    step_cycle(1'b1, 2'd0, 32'h8000_0000, 2'd0);
    check_eq("t6_min_int_remaining", readdata, 32'h8000_0000);
    repeat (3) step_cycle(1'b0, 2'd0, '0, 2'd0);
    step_cycle(1'b1, 2'd2, 32'd1, 2'd0);

    // asynchronous reset mid-move
    step_cycle(1'b1, 2'd0, 32'd20, 2'd0);
    repeat (5) step_cycle(1'b0, 2'd0, '0, 2'd0);
    do_reset();

    // index pulse: period 2, +9 from 0, LOG2 = 2
    step_cycle(1'b1, 2'd1, 32'd2, 2'd1);
    step_cycle(1'b1, 2'd0, 32'd9, 2'd3);
    zpos.delete();
    for (int i = 0; i < 25; i++) begin
      step_cycle(1'b0, 2'd0, '0, 2'd3);
`ifdef QUAD_INDEX_PULSE_EN
      if (channel_z && (zpos.size() == 0 || zpos[zpos.size()-1] != readdata))
        zpos.push_back(readdata);
`endif
    end
`ifdef QUAD_INDEX_PULSE_EN
    check_eq("t6_z_count", 32'(zpos.size()), 32'd2);
    if (zpos.size() == 2) begin
      check_eq("t6_z_pos0", zpos[0], 32'd4);
      check_eq("t6_z_pos1", zpos[1], 32'd8);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 40) begin
        wd = 32'($urandom_range(0, 12));
        if ($urandom_range(0, 1) == 1) wd = 32'd0 - wd;
        if (r < 3) wd = $urandom();
        step_cycle(1'b1, 2'd0, wd, 2'($urandom_range(0, 3)));
      end else if (r < 70) begin
        step_cycle(1'b1, 2'd1, 32'($urandom_range(0, 6)), 2'($urandom_range(0, 3)));
      end else if (r < 95) begin
        step_cycle(1'b1, 2'd2, 32'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end else if (r < 97) begin
        do_reset();
      end else begin
        step_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom(), 2'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
